stock_writer: RTL

STOCK_WRITER -- requirements
Module: stock_writer

---
 rtl/stock_writer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/stock_writer.sv
// stock_writer: commits five 11-bit product records to storage. A record is
// written only when it differs from the last value storage accepted for it.

module stock_writer_rec #(
  parameter int REC_W = 11
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [REC_W-1:0] p_in,
  input  logic             commit,
  input  logic             drop,
  output logic [REC_W-1:0] snap,
  output logic             need_write
);
  logic [REC_W-1:0] snap_q, snap_d;
  logic [REC_W-1:0] shadow_q, shadow_d;
  logic             valid_q, valid_d;

  always_comb begin
    snap_d   = load ? p_in : snap_q;
    shadow_d = shadow_q;
    valid_d  = valid_q;
    if (commit) begin
      shadow_d = snap_q;
      valid_d  = 1'b1;
    end else if (drop) begin
      // abandoned write: storage contents unknown, force a rewrite next time
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      snap_q   <= '0;
      shadow_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      snap_q   <= snap_d;
      shadow_q <= shadow_d;
      valid_q  <= valid_d;
    end
  end

  assign snap       = snap_q;
  assign need_write = !valid_q || (snap_q != shadow_q);
endmodule

module stock_writer #(
  parameter logic [3:0] BASE_ADDR = 4'd0,
  parameter logic [7:0] MAX_WAIT  = 8'd255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] p0,
  input  logic [10:0] p1,
  input  logic [10:0] p2,
  input  logic [10:0] p3,
  input  logic [10:0] p4,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [3:0]  mem_addr,
  output logic [10:0] mem_data,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [7:0]  wr_count
);
  localparam int         NUM_REC  = 5;
  localparam int         REC_W    = 11;
  localparam logic [2:0] LAST_IDX = 3'(NUM_REC - 1);

  typedef enum logic [1:0] {IDLE, CHECK, WRITE, DONE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  wait_q, wait_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_addr_q, mem_addr_d;
  logic [10:0] mem_data_q, mem_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  wr_count_q, wr_count_d;

  logic [NUM_REC-1:0][REC_W-1:0] p_arr, snap_arr;
  logic [NUM_REC-1:0]            need_vec, commit_vec, drop_vec;
  logic                          load, advance;

  assign p_arr = {p4, p3, p2, p1, p0};

  for (genvar g = 0; g < NUM_REC; g++) begin : g_rec
    stock_writer_rec #(.REC_W(REC_W)) u_rec (
      .clock      (clock),
      .reset      (reset),
      .load       (load),
      .p_in       (p_arr[g]),
      .commit     (commit_vec[g]),
      .drop       (drop_vec[g]),
      .snap       (snap_arr[g]),
      .need_write (need_vec[g])
    );
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wait_d     = wait_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    timeout_d  = timeout_q;
    wr_count_d = wr_count_q;
    load       = 1'b0;
    advance    = 1'b0;
    commit_vec = '0;
    drop_vec   = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          idx_d     = '0;
          timeout_d = 1'b0;
          state_d   = CHECK;
        end
      end
      CHECK: begin
        if (need_vec[idx_q]) begin
          state_d    = WRITE;
          mem_we_d   = 1'b1;
          mem_addr_d = BASE_ADDR + {1'b0, idx_q};
          mem_data_d = snap_arr[idx_q];
          wait_d     = '0;
        end else begin
          advance = 1'b1;
        end
      end
      WRITE: begin
        if (mem_ready) begin
          mem_we_d            = 1'b0;
          commit_vec[idx_q]   = 1'b1;
          wr_count_d          = (wr_count_q == 8'hFF) ? wr_count_q : wr_count_q + 8'd1;
          advance             = 1'b1;
        end else if (({1'b0, wait_q} + 9'd1) >= {1'b0, MAX_WAIT}) begin
          // this edge is the MAX_WAIT-th without acceptance
          mem_we_d          = 1'b0;
          timeout_d         = 1'b1;
          drop_vec[idx_q]   = 1'b1;
          advance           = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      DONE: begin
        idx_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (idx_q == LAST_IDX) begin
        state_d = DONE;
      end else begin
        idx_d   = idx_q + 3'd1;
        state_d = CHECK;
      end
    end

    // outputs are registered copies of the next-state view
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      wait_q     <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wait_q     <= wait_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign timeout  = timeout_q;
  assign wr_count = wr_count_q;
endmodule
